// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory bus between two requesters.
// Each access: grant in IDLE, WAIT_CYCLES+1 BUSY cycles, one DONE cycle with ack.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        write0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        write1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_en,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy
);

  // Handshake: reqN is held high until ackN; ackN is a single-cycle pulse in DONE,
  // and rdataN is valid from that cycle until the requester's next DONE.

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic        owner_q;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        grant, win;

  // On a tie the requester that did not own the bus last wins.
  always_comb begin
    grant = (state == IDLE) && (req0 || req1);
    win   = (req0 && req1) ? ~owner_q : req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner_q  <= 1'b1;
      cnt      <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      write_q  <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner_q <= win;
        addr_q  <= win ? addr1  : addr0;
        wdata_q <= win ? wdata1 : wdata0;
        write_q <= win ? write1 : write0;
        cnt     <= WAIT_INIT;
      end
      if (state == BUSY && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (state == DONE) begin
        if (owner_q) rdata1_q <= mem_rdata;
        else         rdata0_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0 || req1) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter still equals its load value only in the first BUSY cycle,
  // which limits each write access to a single write strobe.
  always_comb begin
    mem_en    = (state != IDLE);
    busy      = (state != IDLE);
    mem_addr  = mem_en ? addr_q  : 32'd0;
    mem_wdata = mem_en ? wdata_q : 32'd0;
    mem_write = (state == BUSY) && write_q && (cnt == WAIT_INIT);
    ack0      = (state == DONE) && !owner_q;
    ack1      = (state == DONE) &&  owner_q;
    rdata0    = ack0 ? mem_rdata : rdata0_q;
    rdata1    = ack1 ? mem_rdata : rdata1_q;
    owner     = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (WAIT_CYCLES 0, 3, 2) share stimulus,
// each with its own ROM/RAM model (ROM word i = A000_0000|i, RAM word i = 5000_0000|i).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, write0 = 1'b0, req1 = 1'b0, write1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;

  logic [2:0]        ack0_v, ack1_v, mem_write_v, mem_en_v, owner_v, busy_v;
  logic [2:0][31:0]  rdata0_v, rdata1_v, mem_addr_v, mem_wdata_v;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    logic        ack0_l, ack1_l, mem_write_l, mem_en_l, owner_l, busy_l;
    logic [31:0] rdata0_l, rdata1_l, mem_addr_l, mem_wdata_l;
    logic [31:0] mem_rdata_l = '0;
    logic [31:0] ram [1024];

    initial for (int i = 0; i < 1024; i++) ram[i] = 32'h5000_0000 | 32'(i);

    // Write-first synchronous memory: a write is read back in the same cycle.
    always @(posedge clk) begin
      if (mem_en_l) begin
        if (mem_addr_l[12]) begin
          if (mem_write_l) begin
            ram[mem_addr_l[11:2]] <= mem_wdata_l;
            mem_rdata_l <= mem_wdata_l;
          end else begin
            mem_rdata_l <= ram[mem_addr_l[11:2]];
          end
        end else begin
          mem_rdata_l <= 32'hA000_0000 | {22'd0, mem_addr_l[11:2]};
        end
      end
    end

    mem_arbiter #(.WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0_l), .rdata0(rdata0_l),
      .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1_l), .rdata1(rdata1_l),
      .mem_addr(mem_addr_l), .mem_wdata(mem_wdata_l), .mem_write(mem_write_l),
      .mem_en(mem_en_l), .mem_rdata(mem_rdata_l), .owner(owner_l), .busy(busy_l)
    );

    assign ack0_v[g] = ack0_l;
    assign ack1_v[g] = ack1_l;
    assign mem_write_v[g] = mem_write_l;
    assign mem_en_v[g] = mem_en_l;
    assign owner_v[g] = owner_l;
    assign busy_v[g] = busy_l;
    assign rdata0_v[g] = rdata0_l;
    assign rdata1_v[g] = rdata1_l;
    assign mem_addr_v[g] = mem_addr_l;
    assign mem_wdata_v[g] = mem_wdata_l;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Ticks until the chosen requester's ack on instance k; n = maxc+1 on timeout.
  task automatic wait_ack(input int k, input bit who, input int maxc,
                          output int n, output int wr, output int en,
                          output int other, output logic [31:0] rd);
    n = maxc + 1; wr = 0; en = 0; other = 0; rd = '0;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (mem_en_v[k]) en++;
      if (mem_write_v[k]) wr++;
      if (who ? ack0_v[k] : ack1_v[k]) other++;
      if (who ? ack1_v[k] : ack0_v[k]) begin
        n = i;
        rd = who ? rdata1_v[k] : rdata0_v[k];
        if (who) req1 = 1'b0; else req0 = 1'b0;
        break;
      end
    end
  endtask

  int n, wr, en, other, cnt;
  logic [31:0] rd;

  initial begin
    do_reset();
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_owner", owner_v[0], 1'b1);
    check("rst_ack0", ack0_v[0], 1'b0);
    check("rst_ack1", ack1_v[0], 1'b0);
    check("rst_mem_en", mem_en_v[0], 1'b0);
    check("rst_mem_write", mem_write_v[0], 1'b0);
    check("rst_mem_addr", mem_addr_v[0], 32'd0);
    check("rst_mem_wdata", mem_wdata_v[0], 32'd0);
    check("rst_rdata0", rdata0_v[0], 32'd0);

    // WAIT=0: write then read back RAM 0x1000 (IDLE, BUSY, DONE per access).
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'h1000; wdata0 = 32'hDEADBEEF;
    wait_ack(0, 1'b0, 10, n, wr, en, other, rd);
    check("wr_latency", n, 2);
    check("wr_strobes", wr, 1);
    check("wr_en_cycles", en, 2);
    check("wr_ack1", other, 0);
    tick();
    req0 = 1'b1; write0 = 1'b0;
    wait_ack(0, 1'b0, 10, n, wr, en, other, rd);
    check("rd_latency", n, 2);
    check("rd_strobes", wr, 0);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_ack1", other, 0);
    tick();
    check("rd_hold", rdata0_v[0], 32'hDEADBEEF);

    // WAIT=0: both requesters held high, grants alternate every 3 cycles.
    do_reset();
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h0004;
    req1 = 1'b1; write1 = 1'b0; addr1 = 32'h1008;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("rr_ack0_c%0d", i), ack0_v[0], 32'((i % 6) == 2));
      check($sformatf("rr_ack1_c%0d", i), ack1_v[0], 32'((i % 6) == 5));
      if (i == 2) check("rr_rdata0", rdata0_v[0], 32'hA000_0001);
      if (i == 5) check("rr_rdata1", rdata1_v[0], 32'h5000_0002);
      if (i == 4) check("rr_owner1", owner_v[0], 1'b1);
      if (i == 7) check("rr_owner0", owner_v[0], 1'b0);
    end

    // WAIT=3: req1 reads ROM word 0.
    do_reset();
    req1 = 1'b1; write1 = 1'b0; addr1 = 32'h0000;
    wait_ack(1, 1'b1, 20, n, wr, en, other, rd);
    check("w3_latency", n, 5);
    check("w3_en_cycles", en, 5);
    check("w3_rdata1", rd, 32'hA000_0000);
    check("w3_ack0", other, 0);

    // WAIT=3: req0 arrives while req1 is in BUSY; it is served right after.
    do_reset();
    req1 = 1'b1; write1 = 1'b0; addr1 = 32'h0004;
    tick();
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h100C;
    wait_ack(1, 1'b1, 20, n, wr, en, other, rd);
    check("late_ack1_n", n, 4);
    check("late_rdata1", rd, 32'hA000_0001);
    check("late_no_ack0", other, 0);
    wait_ack(1, 1'b0, 20, n, wr, en, other, rd);
    check("late_ack0_n", n, 6);
    check("late_rdata0", rd, 32'h5000_0003);
    check("late_owner", owner_v[1], 1'b0);

    // WAIT=2: reset in the second BUSY cycle of a req1 read aborts it.
    do_reset();
    req1 = 1'b1; write1 = 1'b0; addr1 = 32'h0008;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req1 = 1'b0;
    check("rst_mid_busy", busy_v[2], 1'b0);
    check("rst_mid_en", mem_en_v[2], 1'b0);
    check("rst_mid_ack1", ack1_v[2], 1'b0);
    check("rst_mid_owner", owner_v[2], 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack1_v[2]) cnt++;
    end
    check("rst_mid_no_ack1", cnt, 0);
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h0008;
    wait_ack(2, 1'b0, 20, n, wr, en, other, rd);
    check("post_rst_n", n, 4);
    check("post_rst_rdata0", rd, 32'hA000_0002);

    // WAIT=3: req0 dropped after the first BUSY cycle still completes once.
    do_reset();
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h0010;
    tick();
    req0 = 1'b0;
    wait_ack(1, 1'b0, 20, n, wr, en, other, rd);
    check("drop_n", n, 4);
    check("drop_rdata0", rd, 32'hA000_0004);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy_v[1] || ack0_v[1]) cnt++;
    end
    check("drop_no_regrant", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
